rf_param_dump: RTL and testbench

//  Parametrised general-purpose register file for the pipelined MIPS core: 2 async read ports, 1 sync write port.

---
 rtl/rf_param_dump.sv | 106 ++++++++++
 tb/tb_rf_param_dump.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param_dump.sv
// rf_param_dump: MIPS GPR file (2 async read ports, 1 sync write port) with a valid/ready dump engine.
// Optional feature macro: RF_BYPASS_EN (same-cycle write->read forwarding on read and dump ports).
module rf_param_dump #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          dump_req,
  output logic          dump_busy,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [DW-1:0] rf [NREG];
  logic          wr_ok;

  // A write to register 0 is dropped when it is hardwired to zero.
  assign wr_ok = we && !(ZERO_REG && (wa == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wa] <= wd;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = rf[a];
`ifdef RF_BYPASS_EN
    if (wr_ok && !rst && (wa == a)) v = wd;
`endif
    if (ZERO_REG && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rd1 = rd_port(ra1);
    rd2 = rd_port(ra2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // The index only advances on an accepted beat and never wraps; DONE follows the last register.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    dump_data  = '0;
    unique case (state)
      IDLE: begin
        if (dump_req) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        dump_data  = rd_port(idx);
        if (dump_ready) begin
          if (&idx) state_nxt = DONE;
          else      idx_nxt   = idx + 1'b1;
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_idx = idx;

endmodule

// File: tb/tb_rf_param_dump.sv
// tb_rf_param_dump: directed table-driven checks of reads/writes plus dump sequences
// (full scan, stalled beat with write, reset mid-scan).
module tb_rf_param_dump;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] rd1, rd2, wd;
  logic          we;
  logic          dump_req, dump_busy, dump_valid, dump_ready, dump_done;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;

  always #5 clk = ~clk;

  rf_param_dump #(.DW(DW), .AW(AW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t          vecs [9];
  logic [DW-1:0] model [NREG];
  logic [DW-1:0] expData;
  logic [AW-1:0] expIdx;
  int            nChecks = 0;
  int            nPass   = 0;
  int            beats;
  int            readyPat [4] = '{1, 0, 0, 1};

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    we  = v.we;
    wa  = v.wa;
    wd  = v.wd;
    ra1 = v.ra1;
    ra2 = v.ra2;
  endtask

  // Advance one clock, mirroring any accepted write into the reference model.
  task automatic step();
    @(posedge clk);
    if (we && !rst && wa != '0) model[wa] = wd;
    #1;
  endtask

  task automatic checkDone(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(dump_done), 32'd1);
    checkOutput({tag, "_done_valid"}, 32'(dump_valid), 32'd0);
    checkOutput({tag, "_done_busy"}, 32'(dump_busy), 32'd1);
    step();
    @(negedge clk);
    checkOutput({tag, "_after_done"}, 32'(dump_done), 32'd0);
    checkOutput({tag, "_after_busy"}, 32'(dump_busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd5,
                BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,
                BYP ? 32'hFFFFFFFF : 32'h0, 32'h12345678};
    vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,
                32'hFFFFFFFF, BYP ? 32'h1 : 32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h1, 32'hFFFFFFFF};
    vecs[7] = '{1'b1, 5'd5,  32'hAAAA5555, 5'd5,  5'd0,
                BYP ? 32'hAAAA5555 : 32'h12345678, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd2,  32'hAAAA5555, 32'h0};

    for (int i = 0; i < NREG; i++) model[i] = '0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd31;
    dump_req = 1'b0; dump_ready = 1'b0;

    #2;
    checkOutput("rst_valid", 32'(dump_valid), 32'd0);
    checkOutput("rst_busy", 32'(dump_busy), 32'd0);
    checkOutput("rst_done", 32'(dump_done), 32'd0);
    checkOutput("rst_data", dump_data, 32'd0);
    checkOutput("rst_rd1", rd1, 32'd0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
      checkOutput($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
      step();
    end
    we = 1'b0;

    // Reset mid-run clears everything
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(dump_busy), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    for (int i = 0; i < NREG; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      @(negedge clk);
      checkOutput($sformatf("clr_rd1_%0d", i), rd1, 32'd0);
      checkOutput($sformatf("clr_rd2_%0d", i), rd2, 32'd0);
      step();
    end

    // Preload RF[i] = i*3
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i * 3);
      step();
    end
    we = 1'b0;

    // Full dump with writes ahead of, behind and at the current index, plus an ignored dump_req
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    for (int b = 0; b < NREG; b++) begin
      we = 1'b0;
      if (b == 3)  begin we = 1'b1; wa = 5'd20; wd = 32'h00000777; end
      if (b == 10) begin we = 1'b1; wa = 5'd2;  wd = 32'h00000999; end
      if (b == 15) begin we = 1'b1; wa = 5'd15; wd = 32'h0000BEEF; end
      dump_req = (b == 5);
      expData = model[b];
      if (BYP && we && wa == 5'(b)) expData = wd;
      @(negedge clk);
      checkOutput($sformatf("d4_valid_%0d", b), 32'(dump_valid), 32'd1);
      checkOutput($sformatf("d4_idx_%0d", b), 32'(dump_idx), 32'(b));
      checkOutput($sformatf("d4_data_%0d", b), dump_data, expData);
      step();
    end
    we = 1'b0;
    dump_req = 1'b0;
    checkDone("d4");
    checkOutput("d4_not_requeued", 32'(dump_valid), 32'd0);

    // Stalled beat with a write to the held index
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    expIdx = '0;
    beats = 0;
    for (int c = 0; c < 40 && beats < NREG; c++) begin
      dump_ready = (c < 4) ? readyPat[c][0] : 1'b1;
      we = (c == 1);
      wa = 5'd1;
      wd = 32'hA5A5A5A5;
      expData = model[expIdx];
      if (BYP && we && wa == expIdx) expData = wd;
      @(negedge clk);
      checkOutput($sformatf("d5_idx_c%0d", c), 32'(dump_idx), 32'(expIdx));
      checkOutput($sformatf("d5_data_c%0d", c), dump_data, expData);
      if (dump_ready) begin
        expIdx = expIdx + 1'b1;
        beats++;
      end
      step();
    end
    we = 1'b0;
    checkOutput("d5_beat_count", 32'(beats), 32'(NREG));
    checkDone("d5");

    // Reset at beat 10, then a fresh dump of a cleared file
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    for (int b = 0; b <= 10; b++) begin
      @(negedge clk);
      checkOutput($sformatf("d6_idx_%0d", b), 32'(dump_idx), 32'(b));
      if (b < 10) step();
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("d6_rst_valid", 32'(dump_valid), 32'd0);
    checkOutput("d6_rst_busy", 32'(dump_busy), 32'd0);
    checkOutput("d6_rst_done", 32'(dump_done), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("d6_nodone_%0d", c), 32'(dump_done), 32'd0);
      checkOutput($sformatf("d6_idle_valid_%0d", c), 32'(dump_valid), 32'd0);
      step();
    end
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int b = 0; b < NREG; b++) begin
      @(negedge clk);
      checkOutput($sformatf("d6b_idx_%0d", b), 32'(dump_idx), 32'(b));
      checkOutput($sformatf("d6b_data_%0d", b), dump_data, 32'd0);
      step();
    end
    checkDone("d6b");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
